// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the 4-bit adder self-test engine: operand width,
// sweep length, internal counter widths and the checker FSM state type.
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int WIDTH       = 4;
  localparam int NUM_VECTORS = 256;

  // idx covers {A,B}; the settle counter holds 1..15; err_count holds 0..256.
  localparam int IDX_W = 2 * WIDTH;
  localparam int CNT_W = 4;
  localparam int ERR_W = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } bist_state_t;

endpackage : adder_pkg

// File: rtl/adder4_ref_model.sv
// -----------------------------------------------------------------------------
// adder4_ref_model
// Combinational expected-sum generator for the adder self-test.
//   a_i   [3:0] operand A
//   b_i   [3:0] operand B
//   sum_o [4:0] zero-extended A + zero-extended B ({cout, S})
// -----------------------------------------------------------------------------
module adder4_ref_model
  import adder_pkg::*;
(
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule : adder4_ref_model

// File: rtl/adder4_bist_checker.sv
// -----------------------------------------------------------------------------
// adder4_bist_checker
// Exhaustive self-test for a 4-bit adder. Sweeps all 256 {A,B} pairs (A outer,
// B inner), waits SETTLE cycles per vector, compares the adder's {cout,S}
// against the reference sum and records an error count plus the first failure.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   start             begin a sweep (accepted in IDLE or DONE)
//   abort             return to IDLE (acted on in RUN only)
//   a_out, b_out      registered operands to the adder under test
//   s_in, cout_in     adder result
//   busy, done, pass  status; pass is meaningful while done is high
//   err_count         number of mismatching vectors, 0..256
//   fail_valid        first-failure record is held
//   fail_a/b/s/cout   first failing operands and sampled result
//   dbg_state         current FSM state
//
// Control semantics: start and abort are level-sampled single-cycle requests,
// no ready/ack; start is consumed on the edge it is seen in IDLE/DONE and
// ignored in RUN; abort is consumed on the edge it is seen in RUN and ignored
// elsewhere. abort beats a sample edge in the same cycle (vector unchecked).
// -----------------------------------------------------------------------------
module adder4_bist_checker
  import adder_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] s_in,
  input  logic             cout_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_s,
  output logic             fail_cout,
  output bist_state_t      dbg_state
);

  localparam logic [CNT_W-1:0] SETTLE_RELOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX       = ERR_W'(NUM_VECTORS);

  bist_state_t      state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic             fail_valid_q;
  logic [WIDTH-1:0] fail_a_q;
  logic [WIDTH-1:0] fail_b_q;
  logic [WIDTH-1:0] fail_s_q;
  logic             fail_cout_q;

  logic [WIDTH:0]   exp_sum;
  logic             mismatch;

  // The vector on a_out/b_out is the one being sampled, so the reference
  // model looks at idx_q directly.
  adder4_ref_model u_ref (
    .a_i   (idx_q[IDX_W-1:WIDTH]),
    .b_i   (idx_q[WIDTH-1:0]),
    .sum_o (exp_sum)
  );

  assign mismatch = ({cout_in, s_in} != exp_sum);

  // Saturating increment; 256 is reachable only if every vector fails.
  always_comb begin
    err_count_d = err_count_q;
    if (mismatch && (err_count_q != ERR_MAX)) begin
      err_count_d = err_count_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      err_count_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      fail_s_q     <= '0;
      fail_cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= RUN;
            idx_q        <= '0;
            cnt_q        <= SETTLE_RELOAD;
            err_count_q  <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
            fail_s_q     <= '0;
            fail_cout_q  <= 1'b0;
          end
        end

        RUN: begin
          if (abort) begin
            // Error count and fail record survive an abort for inspection.
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q == CNT_ONE) begin
            err_count_q <= err_count_d;
            if (mismatch && !fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_a_q     <= idx_q[IDX_W-1:WIDTH];
              fail_b_q     <= idx_q[WIDTH-1:0];
              fail_s_q     <= s_in;
              fail_cout_q  <= cout_in;
            end
            if (idx_q == IDX_LAST) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
              cnt_q   <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
              cnt_q <= SETTLE_RELOAD;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end

        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_out      = idx_q[IDX_W-1:WIDTH];
  assign b_out      = idx_q[WIDTH-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign fail_s     = fail_s_q;
  assign fail_cout  = fail_cout_q;
  assign dbg_state  = state_q;

endmodule : adder4_bist_checker
